bpred_btb: RTL and testbench
============================

BPRED_BTB -- requirements
Module: bpred_btb

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of BTB entries; power of two, 4..64.
REQ-002 SHALL have parameter XLEN, default 32, PC and target width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pcF  input  XLEN  fetch-stage PC being looked up.
REQ-006 SHALL have port pred_takenF  output  1  prediction for pcF; carried down the pipe as pred_takenD/pred_takenE.
REQ-007 SHALL have port pred_targetF  output  XLEN  predicted next PC; carried down as pred_targetD/pred_targetE.
REQ-008 SHALL have port upd_en  input  1  EX resolves a conditional branch this cycle.
REQ-009 SHALL have port upd_pc  input  XLEN  PC of the resolving branch.
REQ-010 SHALL have port upd_taken  input  1  actual outcome.
REQ-011 SHALL have port upd_target  input  XLEN  actual taken target.
REQ-012 SHALL have port pred_takenE  input  1  prediction made for that branch.
REQ-013 SHALL have port pred_targetE  input  XLEN  target predicted for that branch.
REQ-014 SHALL have port mispredict  output  1  redirect request; drives the ID/EX and IF/ID flush.
REQ-015 SHALL have port redirect_pc  output  XLEN  correct next PC when mispredict=1.

Function
REQ-016 SHALL index the table with pc[IDX+1:2] (IDX=log2(ENTRIES)) and tag with pc[XLEN-1:IDX+2].
REQ-017 SHALL hold per entry: valid, tag, target (XLEN), 2-bit saturating counter.
REQ-018 SHALL compute lookup combinationally, zero latency: hit = valid && tag match; pred_takenF = hit && ctr[1].
REQ-019 SHALL drive pred_targetF = stored target when pred_takenF=1, else pcF+4 (mod 2^XLEN, wrap at top of space).
REQ-020 SHALL assert mispredict = upd_en && (upd_taken != pred_takenE || (upd_taken && upd_target != pred_targetE)), combinationally.
REQ-021 SHALL drive redirect_pc = upd_target if upd_taken, else upd_pc+4; value is don't-care when mispredict=0.
REQ-022 SHALL, on upd_en with hit at upd_pc: counter +1 saturating at 11 if taken, -1 saturating at 00 if not; target overwritten with upd_target if taken.
REQ-023 SHALL, on upd_en miss with upd_taken=1: allocate/replace the entry: valid=1, new tag, target=upd_target, ctr=10 (weakly taken).
REQ-024 SHALL, on upd_en miss with upd_taken=0: leave the table unchanged.
REQ-025 SHALL make an update visible to lookup on the cycle after upd_en; a same-cycle lookup of the same index SHALL see the pre-update contents (no bypass).
REQ-026 SHALL make mispredict and redirect_pc independent of table state (pure function of update inputs).

Reset
REQ-027 SHALL, while reset=1 at a clock edge, clear every valid bit and set every counter to 01; tags and targets need not be reset.
REQ-028 SHALL ignore upd_en on any edge where reset=1; lookup during reset SHALL return pred_takenF=0, pred_targetF=pcF+4 from the next edge onward.
REQ-029 SHALL drive mispredict=0 whenever upd_en=0, including during reset.

Configuration
REQ-030 SHALL support macro BPRED_STATS_EN: when defined, add outputs stat_branches and stat_mispredicts (32 bits each), incremented on upd_en and on mispredict, saturating at all-ones, cleared by reset.
REQ-031 SHALL, without BPRED_STATS_EN, omit those ports and counters entirely; prediction behaviour SHALL be identical either way.

Structure
REQ-032 SHALL place counter encodings (SNT=00, WNT=01, WT=10, ST=11), the reset counter value and the allocate counter value in shared package bpred_pkg.
REQ-033 SHALL implement the counter update in sub-module bpred_sat_ctr (inputs ctr, taken; output next ctr), instantiated once on the update path.

Verification
REQ-034 SHALL cover cold miss: after reset, pcF=0x100 -> pred_takenF=0, pred_targetF=0x104.
REQ-035 SHALL cover allocate: upd_en, upd_pc=0x100, taken, target=0x40, pred_takenE=0 -> mispredict=1, redirect_pc=0x40; next cycle pcF=0x100 -> pred_takenF=1, target 0x40.
REQ-036 SHALL cover hysteresis: entry at ctr=10, one not-taken update -> pred_takenF=0; a further taken update -> pred_takenF=1; four taken updates from 00 saturate at 11.
REQ-037 SHALL cover aliasing: entries 0x100 and 0x140 with ENTRIES=16 share index 0 -> allocating 0x140 evicts 0x100; lookup at 0x100 misses.
REQ-038 SHALL cover target mispredict: pred_takenE=1, pred_targetE=0x40, upd_taken=1, upd_target=0x80 -> mispredict=1, redirect_pc=0x80, stored target becomes 0x80.
REQ-039 SHALL cover reset mid-stream and same-cycle conflict: reset with upd_en=1 -> no allocation, all lookups miss; update and lookup of one index in one cycle -> lookup returns old value.

Source files
------------

// File: rtl/bpred_pkg.sv
// Shared encodings for the BTB's 2-bit saturating direction counters.
package bpred_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;
  localparam ctr_e CTR_ALLOC = CTR_WT;

  function automatic logic ctr_taken(input ctr_e c);
    return (c == CTR_WT) || (c == CTR_ST);
  endfunction

endpackage

// File: rtl/bpred_sat_ctr.sv
// Next-state function of a 2-bit saturating direction counter.
module bpred_sat_ctr
  import bpred_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  output ctr_e ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_e'(ctr_i + 2'd1);
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_e'(ctr_i - 2'd1);
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with 2-bit counters, zero-latency lookup.
// Optional statistics counters are built when BPRED_STATS_EN is defined.
module bpred_btb
  import bpred_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pcF,
  output logic            pred_takenF,
  output logic [XLEN-1:0] pred_targetF,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            pred_takenE,
  input  logic [XLEN-1:0] pred_targetE,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  ctr_e               ctr_q    [ENTRIES];
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];

  logic [IDX-1:0]  f_idx, u_idx;
  logic [TAGW-1:0] f_tag, u_tag;
  logic            f_hit, u_hit;
  ctr_e            ctr_d;

  assign f_idx = pcF[IDX+1:2];
  assign f_tag = pcF[XLEN-1:IDX+2];
  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = upd_pc[XLEN-1:IDX+2];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign pred_takenF  = f_hit && ctr_taken(ctr_q[f_idx]);
  assign pred_targetF = pred_takenF ? target_q[f_idx] : pcF + XLEN'(4);

  // Resolution outcome depends only on the EX-stage inputs, never on table state.
  assign mispredict  = upd_en && ((upd_taken != pred_takenE) ||
                                  (upd_taken && (upd_target != pred_targetE)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  bpred_sat_ctr u_sat_ctr (
    .ctr_i   (ctr_q[u_idx]),
    .taken_i (upd_taken),
    .ctr_o   (ctr_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (upd_en) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_d;
      end else if (upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= CTR_ALLOC;
      end
    end
  end

  // Tag and target carry no reset; a taken update either refreshes or allocates.
  always_ff @(posedge clk) begin
    if (!reset && upd_en && upd_taken) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target;
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] branches_q, mispredicts_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      if (upd_en && (branches_q != '1))        branches_q    <= branches_q + 32'd1;
      if (mispredict && (mispredicts_q != '1)) mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;
`else
  // No statistics state in this build; the prediction path above is complete.
`endif

endmodule

// File: tb/tb_bpred_btb.sv
// Scoreboard bench for bpred_btb: directed scenarios followed by a random stream.
module tb_bpred_btb;

  localparam int ENTRIES = 16;
  localparam int XLEN    = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] pcF;
  logic            pred_takenF;
  logic [XLEN-1:0] pred_targetF;
  logic            upd_en;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            pred_takenE;
  logic [XLEN-1:0] pred_targetE;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
`ifdef BPRED_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  always #5 clk = ~clk;

  bpred_btb #(.ENTRIES(ENTRIES), .XLEN(XLEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .pcF          (pcF),
    .pred_takenF  (pred_takenF),
    .pred_targetF (pred_targetF),
    .upd_en       (upd_en),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .pred_takenE  (pred_takenE),
    .pred_targetE (pred_targetE),
    .mispredict   (mispredict),
    .redirect_pc  (redirect_pc)
`ifdef BPRED_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        taken;
    logic [31:0] target;
    logic        misp;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb_q[$];

  // Behavioural reference table
  logic        m_valid [ENTRIES];
  logic [25:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
    int idx;
    logic hit;
    idx = int'(pc[5:2]);
    hit = m_valid[idx] && (m_tag[idx] == pc[31:6]);
    tk  = hit && (m_ctr[idx] >= 2);
    tgt = tk ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic void m_update(input logic rst, input logic ue, input logic [31:0] upc,
                                   input logic ut, input logic [31:0] utgt);
    int idx;
    logic hit;
    if (rst) begin
      m_reset();
      return;
    end
    if (!ue) return;
    idx = int'(upc[5:2]);
    hit = m_valid[idx] && (m_tag[idx] == upc[31:6]);
    if (hit) begin
      if (ut) begin
        if (m_ctr[idx] < 3) m_ctr[idx]++;
        m_tgt[idx] = utgt;
      end else if (m_ctr[idx] > 0) begin
        m_ctr[idx]--;
      end
    end else if (ut) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = upc[31:6];
      m_tgt[idx]   = utgt;
      m_ctr[idx]   = 2;
    end
  endfunction

  // One cycle: drive, push expectation, sample mid-cycle, pop and compare.
  task automatic step(input string tag, input logic rst, input logic [31:0] pc,
                      input logic ue, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic pte, input logic [31:0] ptge);
    exp_t e, got;
    @(posedge clk);
    #1;
    reset = rst; pcF = pc; upd_en = ue; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; pred_takenE = pte; pred_targetE = ptge;
    e.tag = tag;
    m_lookup(pc, e.taken, e.target);
    e.misp = ue && ((ut != pte) || (ut && (utgt != ptge)));
    e.rpc  = ut ? utgt : upc + 32'd4;
    sb_q.push_back(e);
    #3;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check_val({got.tag, "_taken"}, {31'd0, pred_takenF}, {31'd0, got.taken});
      check_val({got.tag, "_target"}, pred_targetF, got.target);
      check_val({got.tag, "_misp"}, {31'd0, mispredict}, {31'd0, got.misp});
      if (got.misp) check_val({got.tag, "_rpc"}, redirect_pc, got.rpc);
    end
    m_update(rst, ue, upc, ut, utgt);
  endtask

  task automatic look(input string tag, input logic [31:0] pc);
    step(tag, 1'b0, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic upd(input string tag, input logic [31:0] pc, input logic [31:0] upc,
                     input logic ut, input logic [31:0] utgt, input logic pte,
                     input logic [31:0] ptge);
    step(tag, 1'b0, pc, 1'b1, upc, ut, utgt, pte, ptge);
  endtask

  initial begin
    logic [31:0] pcs [6];
    logic        tk;
    logic [31:0] tg;
    pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h180;
    pcs[3] = 32'h1C0; pcs[4] = 32'hFFFF_FFFC; pcs[5] = 32'h104;

    m_reset();
    reset = 1'b1; pcF = '0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; pred_takenE = 1'b0; pred_targetE = '0;
    repeat (2) @(posedge clk);

    look("cold", 32'h100);
    check_val("cold_tgt_k", pred_targetF, 32'h104);
    look("wrap", 32'hFFFF_FFFC);
    check_val("wrap_tgt_k", pred_targetF, 32'h0);

    upd("alloc", 32'h200, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    check_val("alloc_rpc_k", redirect_pc, 32'h40);
    look("alloc_hit", 32'h100);
    check_val("alloc_tgt_k", pred_targetF, 32'h40);

    // Hysteresis: 10 -> 01 (not taken), back to 10, then down to 00 and up to 11
    upd("nt1", 32'h200, 32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
    check_val("nt1_rpc_k", redirect_pc, 32'h104);
    look("hyst_nt", 32'h100);
    upd("t1", 32'h200, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    look("hyst_t", 32'h100);
    check_val("hyst_t_k", {31'd0, pred_takenF}, 32'd1);
    for (int i = 0; i < 3; i++) upd("dn", 32'h100, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    look("at_snt", 32'h100);
    for (int i = 0; i < 4; i++) upd("up", 32'h100, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    upd("sat_nt", 32'h100, 32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
    look("sat_chk", 32'h100);
    check_val("sat_k", {31'd0, pred_takenF}, 32'd1);

    // Target mispredict with correct direction
    upd("tgt_mis", 32'h200, 32'h100, 1'b1, 32'h80, 1'b1, 32'h40);
    check_val("tgt_mis_k", {31'd0, mispredict}, 32'd1);
    look("tgt_new", 32'h100);
    check_val("tgt_new_k", pred_targetF, 32'h80);

    // Aliasing: 0x140 shares index 0 with 0x100
    upd("alias", 32'h200, 32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    look("alias_old", 32'h100);
    check_val("alias_old_k", {31'd0, pred_takenF}, 32'd0);
    look("alias_new", 32'h140);

    // Same-cycle update and lookup of one index sees old contents
    upd("same_cyc", 32'h140, 32'h140, 1'b1, 32'h500, 1'b1, 32'h300);
    check_val("same_cyc_k", pred_targetF, 32'h300);
    look("after_same", 32'h140);

    // Reset with an update pending: nothing allocated
    step("rst_upd", 1'b1, 32'h140, 1'b1, 32'h180, 1'b1, 32'h60, 1'b0, 32'h184);
    step("rst_idle", 1'b1, 32'h140, 1'b0, 32'h180, 1'b1, 32'h60, 1'b0, 32'h184);
    check_val("rst_idle_misp_k", {31'd0, mispredict}, 32'd0);
    look("post_rst_a", 32'h180);
    look("post_rst_b", 32'h140);
    check_val("post_rst_k", {31'd0, pred_takenF}, 32'd0);

    // Random stream against the reference table
    for (int n = 0; n < 400; n++) begin
      logic        ue, ut, rst, pte;
      logic [31:0] upc, utgt, ptge;
      rst  = ($urandom_range(0, 59) == 0);
      ue   = ($urandom_range(0, 2) != 0);
      upc  = pcs[$urandom_range(0, 5)];
      ut   = $urandom_range(0, 1) == 1;
      utgt = {$urandom_range(0, 7), 4'h0} & 32'hFF;
      m_lookup(upc, tk, tg);
      pte  = tk;
      ptge = tg;
      if ($urandom_range(0, 3) == 0) pte = ~pte;
      step("rand", rst, pcs[$urandom_range(0, 5)], ue, upc, ut, utgt, pte, ptge);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
